alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: WAIT-state cycles allowed before abort, legal range 1..65535.
REQ-002 SHALL have clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have req_valid in 1, req_ready out 1, req_op in 5, req_x in 32, req_y in 32: command request channel.
REQ-005 SHALL have alu_op out 5, alu_x out 32, alu_y out 32: operation drive into the ALU.
REQ-006 SHALL have alu_done in 1, alu_result in 67, alu_remainder in 33: completion and data returned by the ALU.
REQ-007 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_result out 67, rsp_remainder out 33, rsp_err out 1: response channel.
REQ-008 SHALL have busy out 1: high in every state except IDLE.

Function
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-010 SHALL assert req_ready only in IDLE; accept on the edge where req_valid && req_ready, registering op/x/y.
REQ-011 SHALL treat op codes 1 add, 2 sub, 3 mul, 4 div, 5 shl, 6 shr, 7 and, 8 or, 9 xor as legal; all others illegal.
REQ-012 SHALL, on an accepted illegal op or div with req_y == 0, go IDLE->RESP directly: rsp_err=1, rsp_result=0, rsp_remainder=0, ALU never driven.
REQ-013 SHALL, on an accepted legal op, go IDLE->ISSUE, driving alu_op/alu_x/alu_y from the registered values.
REQ-014 SHALL hold alu_op/alu_x/alu_y stable through ISSUE and WAIT; drive alu_op=0, alu_x=0, alu_y=0 in IDLE and RESP.
REQ-015 SHALL spend exactly one cycle in ISSUE, ignoring alu_done there (stale from a previous op), then go to WAIT with the 16-bit wait counter cleared.
REQ-016 SHALL, in WAIT, when alu_done=1, capture alu_result into rsp_result, rsp_err=0, go RESP.
REQ-017 SHALL capture alu_remainder into rsp_remainder only for op 4; for all other ops rsp_remainder=0.
REQ-018 SHALL, in WAIT, increment the wait counter each cycle alu_done=0; when the counter equals TIMEOUT-1 with alu_done=0, go RESP with rsp_err=1, rsp_result=0, rsp_remainder=0.
REQ-019 SHALL give alu_done priority over timeout when both occur in the same cycle.
REQ-020 SHALL assert rsp_valid only in RESP, holding rsp_result/rsp_remainder/rsp_err stable until rsp_valid && rsp_ready, then go IDLE.
REQ-021 SHALL not accept a new request in the cycle the response handshake completes; next accept earliest one cycle later.
REQ-022 SHALL ignore req_valid and req_* changes while busy=1.
REQ-023 SHALL give latency accept-edge to rsp_valid of 3 cycles when alu_done is high on the first WAIT cycle; N+3 when done arrives N cycles later; 1 cycle for REQ-012 errors.
REQ-024 SHALL hold rsp_result/rsp_remainder/rsp_err at their last captured values outside RESP.

Reset
REQ-025 SHALL, on rst_n low, immediately (without clk) force state IDLE, counter 0, req_ready=0 while rst_n low, all other outputs 0.
REQ-026 SHALL, on reset during any state, abandon the operation with no response; req_ready=1 from the first clk edge after rst_n rises.

Verification
REQ-027 SHALL cover: op=1, X=5, Y=7, alu_done=1 in first WAIT cycle -> rsp_valid 3 cycles after accept, rsp_result=12, rsp_err=0, rsp_remainder=0.
REQ-028 SHALL cover: op=4, X=17, Y=5, done after 33 WAIT cycles -> rsp_result=3, rsp_remainder=2, rsp_err=0, alu_op=4 held through ISSUE and WAIT.
REQ-029 SHALL cover: op=0, then op=12, then op=4 with Y=0 -> each rsp_valid 1 cycle after accept, rsp_err=1, rsp_result=0, alu_op stays 0.
REQ-030 SHALL cover: TIMEOUT=8, op=3, alu_done held 0 -> rsp_err=1, rsp_result=0 after 8 WAIT cycles; alu_done=1 on cycle 8 instead -> normal result.
REQ-031 SHALL cover: rsp_ready held 0 for 10 cycles with req_valid=1 -> rsp fields stable, req_ready=0; on release, next accept one cycle after handshake.
REQ-032 SHALL cover: rst_n pulsed low mid-WAIT between clock edges -> outputs 0 before next edge, no response emitted, new op=7 completes normally after release.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one request at a time through an external ALU and
// returns its result, with illegal-op/div-by-zero rejection and a WAIT timeout.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/ready, req_op/x/y     command request channel
//   alu_op/x/y                      operation driven into the ALU
//   alu_done/result/remainder       completion and data back from the ALU
//   rsp_valid/ready, rsp_result,    response channel
//   rsp_remainder, rsp_err
//   busy                            high in every state except IDLE
module alu_op_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  input  logic        alu_done,
  input  logic [66:0] alu_result,
  input  logic [32:0] alu_remainder,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [66:0] rsp_result,
  output logic [32:0] rsp_remainder,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [4:0]  OP_DIV  = 5'd4;

  logic [1:0]  state;
  logic [4:0]  op_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [15:0] cnt;
  logic        rdy_en;
  logic        legal;
  logic        bad;
  logic        drive;
  logic        accept;

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      (req_op >= 5'd1 && req_op <= 5'd9): legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  assign bad    = !legal || (req_op == OP_DIV && req_y == '0);
  assign accept = req_valid && req_ready;

  // rdy_en keeps req_ready low until the first edge after reset release.
  assign req_ready = rdy_en && (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

  assign drive  = (state == S_ISSUE) || (state == S_WAIT);
  assign alu_op = drive ? op_q : '0;
  assign alu_x  = drive ? x_q  : '0;
  assign alu_y  = drive ? y_q  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      cnt           <= '0;
      rdy_en        <= 1'b0;
      rsp_result    <= '0;
      rsp_remainder <= '0;
      rsp_err       <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= req_op;
            x_q  <= req_x;
            y_q  <= req_y;
            if (bad) begin
              state         <= S_RESP;
              rsp_err       <= 1'b1;
              rsp_result    <= '0;
              rsp_remainder <= '0;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        // alu_done may still be high from the previous op here.
        S_ISSUE: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          if (alu_done) begin
            state         <= S_RESP;
            rsp_err       <= 1'b0;
            rsp_result    <= alu_result;
            rsp_remainder <= (op_q == OP_DIV) ? alu_remainder : '0;
          end else begin
            cnt <= cnt + 16'd1;
            if (cnt == TO_LAST) begin
              state         <= S_RESP;
              rsp_err       <= 1'b1;
              rsp_result    <= '0;
              rsp_remainder <= '0;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: random and directed transactions against a
// transaction-level reference model; two DUTs (TIMEOUT 8 and default).
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [4:0]  req_op = '0;
  logic [31:0] req_x = '0;
  logic [31:0] req_y = '0;
  logic        alu_done = 1'b0;
  logic [66:0] alu_result = '0;
  logic [32:0] alu_remainder = '0;
  logic        rsp_ready = 1'b0;

  logic        req_ready, busy, rsp_valid, rsp_err;
  logic [66:0] rsp_result;
  logic [32:0] rsp_remainder;
  logic [4:0]  alu_op;
  logic [31:0] alu_x, alu_y;

  logic        m_rr, m_bz, m_rv, m_re, t_rr, t_bz, t_rv, t_re;
  logic [66:0] m_res, t_res;
  logic [32:0] m_rem, t_rem;
  logic [4:0]  m_op, t_op;
  logic [31:0] m_x, m_y, t_x, t_y;

  bit sel = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer u_main (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(m_rr),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .alu_op(m_op), .alu_x(m_x), .alu_y(m_y),
    .alu_done(alu_done), .alu_result(alu_result),
    .alu_remainder(alu_remainder),
    .rsp_valid(m_rv), .rsp_ready(rsp_ready),
    .rsp_result(m_res), .rsp_remainder(m_rem),
    .rsp_err(m_re), .busy(m_bz)
  );

  alu_op_sequencer #(.TIMEOUT(8)) u_t8 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(t_rr),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .alu_op(t_op), .alu_x(t_x), .alu_y(t_y),
    .alu_done(alu_done), .alu_result(alu_result),
    .alu_remainder(alu_remainder),
    .rsp_valid(t_rv), .rsp_ready(rsp_ready),
    .rsp_result(t_res), .rsp_remainder(t_rem),
    .rsp_err(t_re), .busy(t_bz)
  );

  assign {req_ready, busy, rsp_valid, rsp_err,
          rsp_result, rsp_remainder, alu_op, alu_x, alu_y} = sel ?
    {t_rr, t_bz, t_rv, t_re, t_res, t_rem, t_op, t_x, t_y} :
    {m_rr, m_bz, m_rv, m_re, m_res, m_rem, m_op, m_x, m_y};

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ALU semantics shared by the stub ALU and the reference model.
  function automatic logic [66:0] golden(logic [4:0] op,
                                         logic [31:0] x,
                                         logic [31:0] y);
    case (op)
      5'd1: return 67'(x) + 67'(y);
      5'd2: return 67'(x) - 67'(y);
      5'd3: return 67'(x) * 67'(y);
      5'd4: return (y != 0) ? 67'(x / y) : '0;
      5'd5: return 67'(x) << y[4:0];
      5'd6: return 67'(x >> y[4:0]);
      5'd7: return 67'(x & y);
      5'd8: return 67'(x | y);
      5'd9: return 67'(x ^ y);
      default: return '0;
    endcase
  endfunction

  // Stub ALU answer; remainder is garbage except for divide.
  function automatic logic [99:0] stub(logic [4:0] op,
                                       logic [31:0] x,
                                       logic [31:0] y);
    logic [32:0] rm;
    rm = {1'b1, $urandom};
    if (op == 5'd4 && y != 0) rm = 33'(x % y);
    return {rm, golden(op, x, y)};
  endfunction

  // d = number of WAIT cycles with alu_done low before it rises.
  task automatic do_txn(logic [4:0] op, logic [31:0] x,
                        logic [31:0] y, int d, int hold, bit keep);
    int tmo, lat, m;
    logic e;
    logic [66:0] r;
    logic [32:0] rm;
    tmo = sel ? 8 : 255;
    if (op < 1 || op > 9 || (op == 4 && y == 0)) begin
      e = 1; r = '0; rm = '0; lat = 1;
    end else if (d >= tmo) begin
      e = 1; r = '0; rm = '0; lat = tmo + 2;
    end else begin
      e = 0; r = golden(op, x, y); lat = d + 3;
      rm = (op == 4) ? 33'(x % y) : '0;
    end
    @(negedge clk);
    req_valid = 1; req_op = op; req_x = x; req_y = y;
    rsp_ready = 0;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    m = 0;
    while (!rsp_valid && m < 400) begin
      check("alu_drive", {busy, alu_op, alu_x, alu_y},
            {1'b1, op, x, y});
      req_valid = 1'($urandom);
      req_op = 5'($urandom); req_x = $urandom; req_y = $urandom;
      if (m == 0) begin
        alu_done = 1'($urandom);
        alu_result = {3'b101, $urandom, $urandom};
        alu_remainder = {1'b1, $urandom};
      end else begin
        alu_done = (m == d + 1);
        {alu_remainder, alu_result} = stub(alu_op, alu_x, alu_y);
      end
      @(posedge clk);
      @(negedge clk);
      m++;
    end
    alu_done = 0;
    check("latency", m + 1, lat);
    check("rsp_fields", {rsp_err, rsp_result, rsp_remainder},
          {e, r, rm});
    check("resp_alu_zero", {req_ready, alu_op, alu_x, alu_y}, 0);
    repeat (hold) begin
      req_valid = keep ? 1'b1 : 1'($urandom);
      req_op = 5'($urandom); req_x = $urandom; req_y = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("rsp_hold",
            {rsp_valid, req_ready, rsp_err, rsp_result, rsp_remainder},
            {1'b1, 1'b0, e, r, rm});
    end
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    req_valid = 0;
    check("after_handshake",
          {busy, rsp_valid, req_ready, rsp_err, rsp_result,
           rsp_remainder},
          {1'b0, 1'b0, 1'b1, e, r, rm});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #2;
    check("rst_ctl", {req_ready, busy, rsp_valid, rsp_err,
                      alu_op, alu_x, alu_y}, 0);
    check("rst_data", {rsp_result, rsp_remainder}, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rdy_before_edge", req_ready, 0);
    @(negedge clk);
    check("rdy_after_edge", {req_ready, busy}, 2'b10);
  endtask

  initial begin
    logic [4:0] op;
    logic [31:0] y;
    sel = 1;
    #3;
    check("reset_ctl", {req_ready, busy, rsp_valid, rsp_err,
                        alu_op, alu_x, alu_y}, 0);
    check("reset_data", {rsp_result, rsp_remainder}, 0);
    do_reset();

    // TIMEOUT = 8 instance
    do_txn(5'd3, 32'd6, 32'd9, 20, 0, 0);
    do_txn(5'd3, 32'd6, 32'd9, 7, 0, 0);
    do_txn(5'd0, 32'd1, 32'd2, 0, 1, 0);
    do_txn(5'd12, 32'd1, 32'd2, 0, 0, 0);
    do_txn(5'd4, 32'd9, 32'd0, 0, 2, 0);
    for (int i = 0; i < 15; i++) begin
      op = 5'($urandom % 16);
      y = ($urandom % 4 == 0) ? 32'd0 : $urandom;
      do_txn(op, $urandom, y, int'($urandom % 13),
             int'($urandom % 3), 0);
    end

    // default TIMEOUT instance
    do_reset();
    sel = 0;
    do_reset();
    do_txn(5'd1, 32'd5, 32'd7, 0, 0, 0);
    do_txn(5'd4, 32'd17, 32'd5, 32, 1, 0);
    do_txn(5'd2, 32'd3, 32'd10, 2, 10, 1);
    do_txn(5'd9, 32'hF0F0, 32'h0FF0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      op = 5'($urandom % 16);
      y = ($urandom % 4 == 0) ? 32'd0 : $urandom;
      do_txn(op, $urandom, y, int'($urandom % 41),
             int'($urandom % 4), 0);
    end

    // async reset in the middle of WAIT
    @(negedge clk);
    req_valid = 1; req_op = 5'd3; req_x = 32'd4; req_y = 32'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    repeat (3) @(negedge clk);
    check("mid_wait_busy", {busy, alu_op}, {1'b1, 5'd3});
    #2;
    rst_n = 0;
    #1;
    check("async_ctl", {req_ready, busy, rsp_valid, rsp_err,
                        alu_op, alu_x, alu_y}, 0);
    check("async_data", {rsp_result, rsp_remainder}, 0);
    alu_done = 1;
    alu_result = 67'd20;
    @(negedge clk);
    #3;
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      check("no_rsp_after_rst", {rsp_valid, busy, req_ready},
            3'b001);
    end
    alu_done = 0;
    do_txn(5'd7, 32'hFF00FF00, 32'h0F0F0F0F, 3, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
